arc4_encrypt: RTL and testbench
===============================

ARC4_ENCRYPT -- requirements
Module: arc4_encrypt

Interface
- REQ-001: clk  input  1  sole clock; all state updates on rising edge.
- REQ-002: rst_n  input  1  asynchronous, active-low reset.
- REQ-003: en  input  1  start pulse; sampled only while rdy=1.
- REQ-004: rdy  output  1  high when idle and able to accept en.
- REQ-005: key  input  24  ARC4 key; key[23:16]=key byte 0, key[7:0]=key byte 2; captured on accepted en.
- REQ-006: pt_addr  output  8  plaintext memory read address.
- REQ-007: pt_rddata  input  8  plaintext read data, valid one cycle after pt_addr (synchronous read).
- REQ-008: ct_addr  output  8  ciphertext memory write address.
- REQ-009: ct_wrdata  output  8  ciphertext write data.
- REQ-010: ct_wren  output  1  write strobe; one byte written per cycle when high.

Function
- REQ-011: Message format: pt[0]=length L (0..255), pt[1..L]=plaintext bytes; the same format is produced in ct, readable by the existing cracker's ct_addr/ct_rddata port.
- REQ-012: States: IDLE, INIT, KSA, LEN, PRGA, DONE; rdy=1 only in IDLE.
- REQ-013: IDLE -> INIT on en=1; key latched in the same cycle; en in any other state is ignored.
- REQ-014: INIT writes S[i]=i for i=0..255, one entry per cycle (256 cycles).
- REQ-015: KSA runs i=0..255: j=(j+S[i]+keybyte[i mod 3]) mod 256, then swap S[i],S[j]; all sums 8-bit wrap.
- REQ-016: LEN reads pt[0], writes ct[0]=L with ct_wren=1.
- REQ-017: PRGA for k=1..L: i=(i+1), j=(j+S[i]), swap, pad=S[(S[i]+S[j]) mod 256], ct[k]=pt[k] XOR pad; i,j restart at 0 on entering PRGA.
- REQ-018: L=0: LEN -> DONE directly; only ct[0] written.
- REQ-019: L=255: k reaches 255 without counter wrap; a 9-bit or compare-before-increment counter is required.
- REQ-020: DONE lasts one cycle, then IDLE with rdy=1.
- REQ-021: ct_wren is high only for the L+1 (or L+2, REQ-027) output writes; never two writes to the same address per message.
- REQ-022: Cycles per state are implementation-defined, but the total from en to rdy SHALL NOT exceed 256 + 4*256 + 4*(L+1) + 8 cycles.

Reset
- REQ-023: Reset clears state to IDLE; rdy=1, ct_wren=0, ct_addr=0, ct_wrdata=0, pt_addr=0, i=j=0.
- REQ-024: Reset asserted mid-operation aborts immediately; no further ct writes; S contents undefined until the next INIT.
- REQ-025: First en after reset release is accepted normally.

Configuration
- REQ-026: Macro ARC4_CT_CHECKSUM_EN selects an appended checksum.
- REQ-027: With ARC4_CT_CHECKSUM_EN defined: after the last PRGA byte, ct[L+1]=XOR of ct[0..L] is written before DONE (for L=255 the checksum write is suppressed).
- REQ-028: Without it: no checksum write; exactly L+1 ct writes.

Structure
- REQ-029: Shared package arc4_pkg holds the state enum, KEY_BYTES=3, S_DEPTH=256, and the key-byte select function.
- REQ-030: State array S lives in sub-module s_mem (256x8, one synchronous read port plus one write port); arc4_encrypt sequences all accesses.

Verification
- REQ-031: key=24'h4B6579 ("Key"), pt="\x09Plaintext" -> ct[0..9]=09 BB F3 16 E8 D9 40 AF 0A D3; rdy returns to 1.
- REQ-032: L=0, any key -> exactly one write, ct[0]=00; rdy=1 within 256+1024+12 cycles.
- REQ-033: L=255, key=24'h000000 -> 256 writes, addresses 0..255 each exactly once; output decrypts back to pt via the same block.
- REQ-034: rst_n pulsed low during KSA -> rdy=1 and ct_wren=0 the same cycle; a new en then reproduces REQ-031 output.
- REQ-035: en held high during PRGA -> no restart; output identical to a single-pulse run.
- REQ-036: ARC4_CT_CHECKSUM_EN defined, REQ-031 stimulus -> ct[10]=XOR(09,BB,F3,16,E8,D9,40,AF,0A,D3); undefined -> no write to address 10.

Source files
------------

// File: rtl/arc4_pkg.sv
// rtl/arc4_pkg.sv - shared ARC4 encrypter types, sizes and key-byte select
package arc4_pkg;

  typedef enum logic [2:0] {IDLE, INIT, KSA, LEN, PRGA, DONE} state_t;

  localparam int KEY_BYTES = 3;
  localparam int S_DEPTH   = 256;

  // Byte 0 of the key is the most significant byte of the 24-bit word.
  function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [1:0] idx);
    case (idx)
      2'd0:    key_byte = key[23:16];
      2'd1:    key_byte = key[15:8];
      default: key_byte = key[7:0];
    endcase
  endfunction

endpackage

// File: rtl/s_mem.sv
// rtl/s_mem.sv - 256x8 ARC4 state array, one synchronous read port and one write port
module s_mem
  import arc4_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] raddr,
  output logic [7:0] rdata,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata
);

  logic [7:0] mem [S_DEPTH];

  // Read-before-write: a read and a write to the same address in one cycle returns the old value.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/arc4_encrypt.sv
// rtl/arc4_encrypt.sv - ARC4 message encrypter; ARC4_CT_CHECKSUM_EN appends an XOR checksum byte
module arc4_encrypt
  import arc4_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rddata,
  output logic [7:0]  ct_addr,
  output logic [7:0]  ct_wrdata,
  output logic        ct_wren
);

  localparam logic [1:0] KIDX_LAST = 2'(KEY_BYTES - 1);

  state_t      state;
  logic [1:0]  phase;
  logic [23:0] key_q;
  logic [7:0]  i, j, si, sj, len, k;
  logic [1:0]  kidx;
  logic        pend, fwd;
`ifdef ARC4_CT_CHECKSUM_EN
  logic [7:0]  csum;
  logic        csum_pend;
`endif

  logic [7:0] s_raddr, s_rdata, s_waddr, s_wdata;
  logic       s_we;
  logic [7:0] j_ksa, j_prga, t_idx, pad, ct_byte;

  s_mem u_s_mem (
    .clk   (clk),
    .raddr (s_raddr),
    .rdata (s_rdata),
    .we    (s_we),
    .waddr (s_waddr),
    .wdata (s_wdata)
  );

  assign rdy     = (state == IDLE);
  assign j_ksa   = j + s_rdata + key_byte(key_q, kidx);
  assign j_prga  = j + s_rdata;
  assign t_idx   = si + sj;
  // The pad read is issued while S[j] is being written, so a hit on j is forwarded.
  assign pad     = fwd ? si : s_rdata;
  assign ct_byte = pt_rddata ^ pad;

  always_comb begin
    s_raddr = i;
    s_we    = 1'b0;
    s_waddr = i;
    s_wdata = i;
    case (state)
      INIT: s_we = 1'b1;
      KSA, PRGA: begin
        case (phase)
          2'd0: s_raddr = (state == PRGA) ? i + 8'd1 : i;
          2'd1: s_raddr = (state == PRGA) ? j_prga : j_ksa;
          2'd2: begin
            s_we    = 1'b1;
            s_wdata = s_rdata;
          end
          default: begin
            s_we    = 1'b1;
            s_waddr = j;
            s_wdata = si;
            s_raddr = t_idx;
          end
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase     <= 2'd0;
      key_q     <= '0;
      i         <= '0;
      j         <= '0;
      si        <= '0;
      sj        <= '0;
      len       <= '0;
      k         <= '0;
      kidx      <= '0;
      pend      <= 1'b0;
      fwd       <= 1'b0;
      pt_addr   <= '0;
      ct_addr   <= '0;
      ct_wrdata <= '0;
      ct_wren   <= 1'b0;
`ifdef ARC4_CT_CHECKSUM_EN
      csum      <= '0;
      csum_pend <= 1'b0;
`endif
    end else begin
      ct_wren <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            key_q   <= key;
            i       <= '0;
            j       <= '0;
            pt_addr <= '0;
            state   <= INIT;
          end
        end
        INIT: begin
          i <= i + 8'd1;
          if (i == 8'hFF) begin
            phase <= 2'd0;
            kidx  <= '0;
            j     <= '0;
            state <= KSA;
          end
        end
        KSA: begin
          phase <= phase + 2'd1;
          if (phase == 2'd1) begin
            j  <= j_ksa;
            si <= s_rdata;
          end else if (phase == 2'd3) begin
            i    <= i + 8'd1;
            kidx <= (kidx == KIDX_LAST) ? 2'd0 : kidx + 2'd1;
            if (i == 8'hFF) state <= LEN;
          end
        end
        LEN: begin
          len       <= pt_rddata;
          ct_addr   <= '0;
          ct_wrdata <= pt_rddata;
          ct_wren   <= 1'b1;
          i         <= '0;
          j         <= '0;
          phase     <= 2'd0;
          pend      <= 1'b0;
          k         <= 8'd1;
          pt_addr   <= 8'd1;
`ifdef ARC4_CT_CHECKSUM_EN
          csum      <= pt_rddata;
`endif
          state     <= (pt_rddata == 8'd0) ? DONE : PRGA;
        end
        PRGA: begin
`ifdef ARC4_CT_CHECKSUM_EN
          if (csum_pend) begin
            ct_addr   <= len + 8'd1;
            ct_wrdata <= csum;
            ct_wren   <= 1'b1;
            csum_pend <= 1'b0;
            state     <= DONE;
          end else
`endif
          case (phase)
            2'd0: begin
              if (pend) begin
                ct_addr   <= k;
                ct_wrdata <= ct_byte;
                ct_wren   <= 1'b1;
                pend      <= 1'b0;
`ifdef ARC4_CT_CHECKSUM_EN
                csum      <= csum ^ ct_byte;
`endif
              end
              // k is compared before it is incremented so L=255 never needs a 9th bit.
              if (pend && k == len) begin
`ifdef ARC4_CT_CHECKSUM_EN
                if (len != 8'hFF) csum_pend <= 1'b1;
                else              state     <= DONE;
`else
                state <= DONE;
`endif
              end else begin
                i     <= i + 8'd1;
                phase <= 2'd1;
                if (pend) begin
                  k       <= k + 8'd1;
                  pt_addr <= k + 8'd1;
                end
              end
            end
            2'd1: begin
              j     <= j_prga;
              si    <= s_rdata;
              phase <= 2'd2;
            end
            2'd2: begin
              sj    <= s_rdata;
              phase <= 2'd3;
            end
            default: begin
              fwd   <= (t_idx == j);
              pend  <= 1'b1;
              phase <= 2'd0;
            end
          endcase
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_encrypt.sv
// tb/tb_arc4_encrypt.sv - randomized self-checking bench for arc4_encrypt against an ARC4 reference model
module tb_arc4_encrypt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [23:0] key = '0;
  logic        rdy;
  logic [7:0]  pt_addr, pt_rddata, ct_addr, ct_wrdata;
  logic        ct_wren;

  always #5 clk = ~clk;

  arc4_encrypt dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rdy       (rdy),
    .key       (key),
    .pt_addr   (pt_addr),
    .pt_rddata (pt_rddata),
    .ct_addr   (ct_addr),
    .ct_wrdata (ct_wrdata),
    .ct_wren   (ct_wren)
  );

  logic [7:0] pt_mem [256];
  logic [7:0] ct_mem [256];
  int         wcnt   [256];
  int         nwr;
  logic       cap_clr = 1'b0;
  logic [7:0] exp_ct [257];
  int         exp_nwr;
  logic [7:0] orig   [256];
  logic [7:0] kv     [10];
  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc;

  always @(posedge clk) pt_rddata <= pt_mem[pt_addr];

  always @(posedge clk) begin
    if (cap_clr) begin
      for (int a = 0; a < 256; a++) wcnt[a] <= 0;
      nwr <= 0;
    end else if (ct_wren) begin
      ct_mem[ct_addr] <= ct_wrdata;
      wcnt[ct_addr]   <= wcnt[ct_addr] + 1;
      nwr             <= nwr + 1;
    end
  end

  task automatic check(input string tag, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Textbook ARC4 on integer arrays; output framed as length byte, ciphertext, optional checksum.
  task automatic model(input logic [23:0] k);
    int s [256];
    int ii, jj, tmp, len, kb, x;
    len = pt_mem[0];
    for (int n = 0; n < 256; n++) s[n] = n;
    jj = 0;
    for (int n = 0; n < 256; n++) begin
      kb  = (k >> (16 - 8 * (n % 3))) & 255;
      jj  = (jj + s[n] + kb) % 256;
      tmp = s[n]; s[n] = s[jj]; s[jj] = tmp;
    end
    ii = 0; jj = 0;
    exp_ct[0] = 8'(len);
    x = len;
    for (int n = 1; n <= len; n++) begin
      ii  = (ii + 1) % 256;
      jj  = (jj + s[ii]) % 256;
      tmp = s[ii]; s[ii] = s[jj]; s[jj] = tmp;
      exp_ct[n] = pt_mem[n] ^ 8'(s[(s[ii] + s[jj]) % 256]);
      x = x ^ exp_ct[n];
    end
    exp_nwr = len + 1;
`ifdef ARC4_CT_CHECKSUM_EN
    if (len < 255) begin
      exp_ct[len + 1] = 8'(x);
      exp_nwr = len + 2;
    end
`endif
  endtask

  task automatic start(input logic [23:0] k);
    @(negedge clk) cap_clr = 1'b1;
    @(negedge clk) cap_clr = 1'b0;
    key = k;
    en  = 1'b1;
    @(negedge clk) en = 1'b0;
  endtask

  task automatic wait_rdy(input int bound, output int c);
    c = 1;
    while (!rdy && c < bound) begin
      @(negedge clk);
      c++;
    end
    check("rdy_timeout", int'(rdy), 1);
  endtask

  task automatic verify(input string tag);
    for (int a = 0; a < exp_nwr; a++) begin
      check({tag, "_ct"}, int'(ct_mem[a]), int'(exp_ct[a]));
      check({tag, "_wcnt"}, wcnt[a], 1);
    end
    if (exp_nwr < 256) check({tag, "_nowrite_past_end"}, wcnt[exp_nwr], 0);
    check({tag, "_nwr"}, nwr, exp_nwr);
  endtask

  task automatic run(input logic [23:0] k, input string tag);
    model(k);
    start(k);
    wait_rdy(256 + 1024 + 4 * (int'(pt_mem[0]) + 1) + 8, cyc);
    verify(tag);
  endtask

  task automatic load_known();
    logic [7:0] msg [10];
    msg = '{8'h09, "P", "l", "a", "i", "n", "t", "e", "x", "t"};
    for (int a = 0; a < 256; a++) pt_mem[a] = 8'(a * 7);
    for (int a = 0; a < 10; a++) pt_mem[a] = msg[a];
  endtask

  task automatic check_known(input string tag);
    for (int a = 0; a < 10; a++) check({tag, "_vec"}, int'(ct_mem[a]), int'(kv[a]));
  endtask

  initial begin
    kv = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    for (int a = 0; a < 256; a++) begin
      pt_mem[a] = '0;
      ct_mem[a] = '0;
    end

    repeat (3) @(negedge clk);
    check("rst_rdy", int'(rdy), 1);
    check("rst_ct_wren", int'(ct_wren), 0);
    check("rst_ct_addr", int'(ct_addr), 0);
    check("rst_ct_wrdata", int'(ct_wrdata), 0);
    check("rst_pt_addr", int'(pt_addr), 0);
    rst_n = 1'b1;

    load_known();
    run(24'h4B6579, "known");
    check_known("known");
    check("known_rdy", int'(rdy), 1);

    pt_mem[0] = 8'd0;
    run(24'($urandom), "len0");
    check("len0_cycles_in_budget", int'(cyc <= 256 + 1024 + 12), 1);

    pt_mem[0] = 8'd255;
    for (int a = 1; a < 256; a++) pt_mem[a] = 8'($urandom);
    for (int a = 0; a < 256; a++) orig[a] = pt_mem[a];
    run(24'h000000, "len255");
    for (int a = 0; a < 256; a++) pt_mem[a] = ct_mem[a];
    run(24'h000000, "len255_dec");
    for (int a = 0; a < 256; a++) check("len255_roundtrip", int'(ct_mem[a]), int'(orig[a]));

    load_known();
    start(24'h4B6579);
    repeat (600) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("ksa_reset_rdy", int'(rdy), 1);
    check("ksa_reset_ct_wren", int'(ct_wren), 0);
    @(negedge clk);
    check("ksa_reset_no_writes", nwr, 0);
    rst_n = 1'b1;
    run(24'h4B6579, "after_reset");
    check_known("after_reset");

    load_known();
    model(24'h4B6579);
    start(24'h4B6579);
    repeat (1285) @(negedge clk);
    en = 1'b1;
    repeat (20) @(negedge clk);
    en = 1'b0;
    wait_rdy(2000, cyc);
    verify("en_held");
    check_known("en_held");

    for (int r = 0; r < 4; r++) begin
      pt_mem[0] = 8'($urandom_range(1, 40));
      for (int a = 1; a < 256; a++) pt_mem[a] = 8'($urandom);
      run(24'($urandom), "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
